// File: rtl/vending_pkg.sv
// Shared types and constants for the coin-operated vend controller.
package vending_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VEND    = 2'd2,
      CHANGE  = 2'd3
   } state_t;

   localparam int NICKEL_V  = 1;
   localparam int DIME_V    = 2;
   localparam int QUARTER_V = 5;

   // Coin-return pulses, bit order {quarter, dime, nickel}
   typedef enum logic [2:0] {
      RET_NONE    = 3'b000,
      RET_NICKEL  = 3'b001,
      RET_DIME    = 3'b010,
      RET_QUARTER = 3'b100
   } ret_t;

endpackage

// File: rtl/vending_controller_change_dispenser.sv
// Greedy change selection: picks the largest coin not exceeding credit and
// reports what is left after returning it.
module change_dispenser
   import vending_pkg::*;
#(
   parameter int CREDIT_W = 7
) (
   input  logic [CREDIT_W-1:0] credit,
   output ret_t                coin,
   output logic [CREDIT_W-1:0] remain
);

   localparam logic [CREDIT_W-1:0] Q_C = CREDIT_W'(QUARTER_V);
   localparam logic [CREDIT_W-1:0] D_C = CREDIT_W'(DIME_V);
   localparam logic [CREDIT_W-1:0] N_C = CREDIT_W'(NICKEL_V);

   always_comb begin
      coin   = RET_NONE;
      remain = credit;
      if (credit >= Q_C) begin
         coin   = RET_QUARTER;
         remain = credit - Q_C;
      end else if (credit >= D_C) begin
         coin   = RET_DIME;
         remain = credit - D_C;
      end else if (credit != '0) begin
         coin   = RET_NICKEL;
         remain = credit - N_C;
      end
   end

endmodule

// File: rtl/vending_controller.sv
// Coin vend controller: credit accumulation, one-cycle vend, greedy change
// and refund, with registered outputs throughout.
//
// state   | meaning
// IDLE    | no credit, accepting coins
// COLLECT | partial credit below price, accepting coins
// VEND    | soda pulse cycle, price deducted at end of cycle
// CHANGE  | returning one coin per cycle until credit is zero
module vending_controller
   import vending_pkg::*;
#(
   parameter int PRICE    = 4,
   parameter int CREDIT_W = 7
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                nickel,
   input  logic                dime,
   input  logic                quarter,
   input  logic                cancel,
   output logic                soda,
   output logic                ret_nickel,
   output logic                ret_dime,
   output logic                ret_quarter,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(PRICE + 4);

   state_t              state, state_n;
   logic [CREDIT_W-1:0] credit_n, coin_val;
   logic [CREDIT_W-1:0] after, after_n;
   logic [1:0]          coin_cnt;
   logic                any_coin, reject_n;
   ret_t                ret_q, ret_n, disp_coin;

   assign coin_cnt = {1'b0, nickel} + {1'b0, dime} + {1'b0, quarter};
   assign any_coin = nickel | dime | quarter;

   always_comb begin
      coin_val = '0;
      if (quarter)
         coin_val = CREDIT_W'(QUARTER_V);
      else if (dime)
         coin_val = CREDIT_W'(DIME_V);
      else if (nickel)
         coin_val = CREDIT_W'(NICKEL_V);
   end

   // The dispenser looks at next-cycle credit so the return pulse can be
   // registered alongside the CHANGE state; 'after' holds what remains once
   // the coin shown this cycle has gone out.
   change_dispenser #(.CREDIT_W(CREDIT_W)) u_disp (
      .credit (credit_n),
      .coin   (disp_coin),
      .remain (after_n)
   );

   always_comb begin
      state_n  = state;
      credit_n = credit;
      reject_n = 1'b0;
      unique case (state)
         IDLE, COLLECT: begin
            if (cancel) begin
               reject_n = any_coin;
               state_n  = (credit != '0) ? CHANGE : IDLE;
            end else if (coin_cnt == 2'd1) begin
               credit_n = credit + coin_val;
               state_n  = (credit_n >= PRICE_C) ? VEND : COLLECT;
            end else if (coin_cnt > 2'd1) begin
               reject_n = 1'b1;
            end
         end
         VEND: begin
            reject_n = any_coin;
            credit_n = credit - PRICE_C;
            state_n  = (credit_n != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            reject_n = any_coin;
            credit_n = after;
            state_n  = (credit_n != '0) ? CHANGE : IDLE;
         end
         default: state_n = IDLE;
      endcase
      ret_n = (state_n == CHANGE) ? disp_coin : RET_NONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         credit      <= '0;
         after       <= '0;
         ret_q       <= RET_NONE;
         soda        <= 1'b0;
         coin_reject <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         credit      <= credit_n;
         after       <= after_n;
         ret_q       <= ret_n;
         soda        <= (state_n == VEND);
         coin_reject <= reject_n;
         busy        <= (state_n == VEND) || (state_n == CHANGE);
      end
   end

   assign ret_nickel  = ret_q[0];
   assign ret_dime    = ret_q[1];
   assign ret_quarter = ret_q[2];

   credit_bound: assert property (@(posedge clk) disable iff (reset) credit <= MAX_C);

endmodule

// File: tb/tb_vending_controller.sv
// Directed-vector bench for vending_controller at PRICE=4, plus a PRICE=1
// instance exercised by a hand-written change sequence.
module tb_vending_controller;

   logic clk = 1'b0;
   logic reset;
   logic nickel, dime, quarter, cancel;
   logic soda, ret_nickel, ret_dime, ret_quarter, coin_reject, busy;
   logic [6:0] credit;

   logic n1, d1, q1, c1;
   logic soda1, rn1, rd1, rq1, rej1, busy1;
   logic [6:0] credit1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   vending_controller #(.PRICE(4), .CREDIT_W(7)) dut (
      .clk(clk), .reset(reset), .nickel(nickel), .dime(dime), .quarter(quarter),
      .cancel(cancel), .soda(soda), .ret_nickel(ret_nickel), .ret_dime(ret_dime),
      .ret_quarter(ret_quarter), .coin_reject(coin_reject), .credit(credit), .busy(busy)
   );

   vending_controller #(.PRICE(1), .CREDIT_W(7)) dut1 (
      .clk(clk), .reset(reset), .nickel(n1), .dime(d1), .quarter(q1),
      .cancel(c1), .soda(soda1), .ret_nickel(rn1), .ret_dime(rd1),
      .ret_quarter(rq1), .coin_reject(rej1), .credit(credit1), .busy(busy1)
   );

   typedef struct {
      string      name;
      logic       rst, n, d, q, c;
      logic       e_soda;
      logic [2:0] e_ret;   // {quarter, dime, nickel}
      logic       e_rej;
      logic [6:0] e_credit;
      logic       e_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input logic rst, n, d, q, c,
                      input logic e_soda, input logic [2:0] e_ret, input logic e_rej,
                      input int e_credit, input logic e_busy);
      vec_t v;
      v.name = name; v.rst = rst; v.n = n; v.d = d; v.q = q; v.c = c;
      v.e_soda = e_soda; v.e_ret = e_ret; v.e_rej = e_rej;
      v.e_credit = 7'(e_credit); v.e_busy = e_busy;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      int total, dimes, cycles, other;
      logic [11:0] act, exp;
      reset = 1'b1; nickel = 0; dime = 0; quarter = 0; cancel = 0;
      n1 = 0; d1 = 0; q1 = 0; c1 = 0;

      //   name          rst n d q c   soda ret    rej cred busy
      add("reset",        1, 0,0,0,0,  0, 3'b000, 0, 0, 0);
      add("n1",           0, 1,0,0,0,  0, 3'b000, 0, 1, 0);
      add("d3",           0, 0,1,0,0,  0, 3'b000, 0, 3, 0);
      add("n4_vend",      0, 1,0,0,0,  1, 3'b000, 0, 4, 1);
      add("vend_exact",   0, 0,0,0,0,  0, 3'b000, 0, 0, 0);
      add("idle",         0, 0,0,0,0,  0, 3'b000, 0, 0, 0);
      add("d2",           0, 0,1,0,0,  0, 3'b000, 0, 2, 0);
      add("q7_vend",      0, 0,0,1,0,  1, 3'b000, 0, 7, 1);
      add("chg_dime",     0, 0,0,0,0,  0, 3'b010, 0, 3, 1);
      add("chg_nickel",   0, 0,0,0,0,  0, 3'b001, 0, 1, 1);
      add("chg_done",     0, 0,0,0,0,  0, 3'b000, 0, 0, 0);
      add("d2b",          0, 0,1,0,0,  0, 3'b000, 0, 2, 0);
      add("cancel_n",     0, 1,0,0,1,  0, 3'b010, 1, 2, 1);
      add("refund_done",  0, 0,0,0,0,  0, 3'b000, 0, 0, 0);
      add("cancel_zero",  0, 0,0,0,1,  0, 3'b000, 0, 0, 0);
      add("cancel0_d",    0, 0,1,0,1,  0, 3'b000, 1, 0, 0);
      add("n_plus_d",     0, 1,1,0,0,  0, 3'b000, 1, 0, 0);
      add("after_rej",    0, 0,0,0,0,  0, 3'b000, 0, 0, 0);
      add("n1b",          0, 1,0,0,0,  0, 3'b000, 0, 1, 0);
      add("d3b",          0, 0,1,0,0,  0, 3'b000, 0, 3, 0);
      add("q8_vend",      0, 0,0,1,0,  1, 3'b000, 0, 8, 1);
      add("chg4_dime",    0, 0,0,0,0,  0, 3'b010, 0, 4, 1);
      add("coin_in_chg",  0, 1,0,0,0,  0, 3'b010, 1, 2, 1);
      add("chg4_done",    0, 0,0,0,0,  0, 3'b000, 0, 0, 0);
      add("q5_vend",      0, 0,0,1,0,  1, 3'b000, 0, 5, 1);
      add("cancel_vend",  0, 0,0,0,1,  0, 3'b001, 0, 1, 1);
      add("chg5_done",    0, 0,0,0,0,  0, 3'b000, 0, 0, 0);
      add("q5_vend_b",    0, 0,0,1,0,  1, 3'b000, 0, 5, 1);
      add("reset_in_vend",1, 0,0,0,0,  0, 3'b000, 0, 0, 0);
      add("post_rst1",    0, 0,0,0,0,  0, 3'b000, 0, 0, 0);
      add("post_rst2",    0, 0,0,0,0,  0, 3'b000, 0, 0, 0);

      foreach (vecs[i]) begin
         reset = vecs[i].rst; nickel = vecs[i].n; dime = vecs[i].d;
         quarter = vecs[i].q; cancel = vecs[i].c;
         @(posedge clk); #1;
         act = {soda, ret_quarter, ret_dime, ret_nickel, coin_reject, busy, credit[5:0]};
         exp = {vecs[i].e_soda, vecs[i].e_ret, vecs[i].e_rej, vecs[i].e_busy,
                vecs[i].e_credit[5:0]};
         chk(vecs[i].name, int'(act), int'(exp));
         chk({vecs[i].name, "_msb"}, int'(credit[6]), int'(vecs[i].e_credit[6]));
      end
      reset = 0; nickel = 0; dime = 0; quarter = 0; cancel = 0;

      // PRICE=1: quarter buys, remainder 4 returned as two dimes.
      chk("p1_idle_credit", int'(credit1), 0);
      q1 = 1'b1;
      @(posedge clk); #1;
      q1 = 1'b0;
      chk("p1_soda", int'({soda1, busy1}), 3);
      chk("p1_vend_credit", int'(credit1), 5);
      total = 0; dimes = 0; cycles = 0; other = 0;
      while (cycles < 10) begin
         @(posedge clk); #1;
         cycles++;
         total += int'(rn1) + 2 * int'(rd1) + 5 * int'(rq1);
         dimes += int'(rd1);
         other += int'(rn1) + int'(rq1) + int'(soda1) + int'(rej1);
         if (!busy1) break;
      end
      chk("p1_busy_falls", cycles, 3);
      chk("p1_total_units", total, 4);
      chk("p1_dimes", dimes, 2);
      chk("p1_other_pulses", other, 0);
      chk("p1_final_credit", int'(credit1), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
